ghash_ctrl_seq: RTL

GHASH_CTRL_SEQ -- requirements
Module: ghash_ctrl_seq

---
 rtl/ghash_ctrl_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ghash_ctrl_seq.sv
// Sequencer that feeds message beats, bubbles and the lengths block into a two-lane GHASH core.
// States: IDLE wait start | ARM core reset | DATA beats | LEN lengths block | DRAIN core latency | DONE capture tag. Optional: GHASH_CTRL_BEAT_COUNT_EN.
module ghash_ctrl_seq #(
    parameter int NB_BLOCK     = 128,
    parameter int N_BLOCKS     = 2,
    parameter int NB_DATA      = N_BLOCKS * NB_BLOCK,
    parameter int CORE_LATENCY = 2
) (
    input  logic                i_clock,
    input  logic                i_reset,
    input  logic                i_start,
    input  logic [NB_DATA-1:0]  i_data,
    input  logic [N_BLOCKS-1:0] i_skip,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_last,
    input  logic [NB_BLOCK-1:0] i_len_block,
    output logic [NB_DATA-1:0]  o_core_data_x,
    output logic [N_BLOCKS-1:0] o_core_skip_bus,
    output logic                o_core_sop,
    output logic                o_core_valid,
    output logic                o_core_reset,
    input  logic [NB_BLOCK-1:0] i_core_y,
    output logic [NB_BLOCK-1:0] o_tag,
    output logic                o_tag_valid,
    output logic                o_busy
`ifdef GHASH_CTRL_BEAT_COUNT_EN
    ,
    output logic [31:0]         o_beat_count
`endif
);

    localparam int NB_CNT = (CORE_LATENCY > 1) ? $clog2(CORE_LATENCY + 1) : 1;
    localparam logic [NB_CNT-1:0] DRAIN_LOAD = NB_CNT'(CORE_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_DATA,
        ST_LEN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                phase;
    logic                sop_pend;
    logic [NB_BLOCK-1:0] len_q;
    logic [NB_CNT-1:0]   drain_cnt;
    logic [NB_BLOCK-1:0] tag_q;
    logic                tag_valid_q;
    logic                beat_accept;

    assign beat_accept = (state == ST_DATA) && i_valid;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state       <= ST_IDLE;
            phase       <= 1'b0;
            sop_pend    <= 1'b0;
            len_q       <= '0;
            drain_cnt   <= '0;
            tag_q       <= '0;
            tag_valid_q <= 1'b0;
        end else begin
            state       <= state_next;
            phase       <= (state == ST_ARM) ? 1'b1 : ~phase;
            tag_valid_q <= (state == ST_DONE);
            if (state == ST_ARM)
                sop_pend <= 1'b1;
            else if (beat_accept)
                sop_pend <= 1'b0;
            if (beat_accept && i_last)
                len_q <= i_len_block;
            if (state == ST_LEN)
                drain_cnt <= DRAIN_LOAD;
            else if ((state == ST_DRAIN) && (drain_cnt != '0))
                drain_cnt <= drain_cnt - 1'b1;
            if (state == ST_DONE)
                tag_q <= i_core_y;
        end
    end

    always_comb begin
        state_next      = state;
        o_ready         = 1'b0;
        o_core_data_x   = '0;
        o_core_skip_bus = '0;
        o_core_sop      = 1'b0;
        o_core_valid    = 1'b0;
        o_busy          = 1'b0;
        o_core_reset    = i_reset || (state == ST_ARM);
        if (!i_reset) begin
            o_busy = (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (i_start)
                        state_next = ST_ARM;
                end
                ST_ARM: begin
                    state_next = ST_DATA;
                end
                ST_DATA: begin
                    o_ready      = 1'b1;
                    o_core_valid = 1'b1;
                    if (i_valid) begin
                        o_core_data_x   = i_data;
                        o_core_skip_bus = i_skip;
                        o_core_sop      = sop_pend;
                        if (i_last)
                            state_next = ST_LEN;
                    end else begin
                        // bubble: all lanes skipped so the core keeps its even/odd phase
                        o_core_skip_bus = '1;
                    end
                end
                ST_LEN: begin
                    o_core_valid    = 1'b1;
                    o_core_data_x   = NB_DATA'(len_q) << (NB_DATA - NB_BLOCK);
                    o_core_skip_bus = {N_BLOCKS{1'b1}} >> 1;
                    state_next      = ST_DRAIN;
                end
                ST_DRAIN: begin
                    if ((drain_cnt == '0) && phase)
                        state_next = ST_DONE;
                end
                ST_DONE: begin
                    state_next = ST_IDLE;
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end
    end

    assign o_tag       = i_reset ? '0 : tag_q;
    assign o_tag_valid = tag_valid_q && !i_reset;

`ifdef GHASH_CTRL_BEAT_COUNT_EN
    logic [31:0] beat_cnt;

    always_ff @(posedge i_clock) begin
        if (i_reset)
            beat_cnt <= '0;
        else if (state == ST_ARM)
            beat_cnt <= '0;
        else if (beat_accept && (beat_cnt != 32'hFFFF_FFFF))
            beat_cnt <= beat_cnt + 32'd1;
    end

    assign o_beat_count = beat_cnt;
`endif

endmodule
